// File: rtl/ram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module   : ram_readback_checker
// Purpose  : Read-only checker that scans an address window on one RAM port.
//            Each returned word is compared against the pattern
//            SEED ^ zero_extend(addr). The block reports pass/fail, a
//            saturating mismatch count, and the first failing address/data.
//            The port is never written: we is tied low.
// Ports    : clk_a          - clock, all logic on rising edge
//            reset          - synchronous, active-low
//            start          - level-sampled; starts a scan from IDLE or DONE
//            q              - RAM read data
//            addr           - RAM address
//            we             - RAM write enable, constant 0
//            busy           - scan in progress
//            done           - scan finished; held until next start/reset
//            pass           - done with zero mismatches
//            err_count      - mismatch count, saturates at 8'hFF
//            first_err_addr - address of the first mismatch (0 if none)
//            first_err_data - data read at the first mismatch (0 if none)
// Options  : STOP_ON_ERR_EN - when defined, the first mismatch ends the scan
//            and addr holds the failing address.
// Revision : 1.0 - initial release
// ============================================================================
module ram_readback_checker #(
  parameter int             dw         = 16,
  parameter int             aw         = 10,
  parameter int             START_ADDR = 0,
  parameter int             END_ADDR   = 15,
  parameter logic [dw-1:0]  SEED       = 16'hA5A5,
  parameter int             RD_LAT     = 1,
  parameter int             HOLD       = 0
) (
  input  logic          clk_a,
  input  logic          reset,
  input  logic          start,
  input  logic [dw-1:0] q,
  output logic [aw-1:0] addr,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [aw-1:0] first_err_addr,
  output logic [dw-1:0] first_err_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [aw-1:0] c_START     = aw'(START_ADDR);
  localparam logic [aw-1:0] c_END       = aw'(END_ADDR);
  // Counters compare against "last cycle" values so WAIT lasts exactly RD_LAT
  // cycles and HOLD exactly HOLD cycles after the counter is zeroed on entry.
  localparam logic [15:0]   c_LAT_LAST  = 16'(RD_LAT - 1);
  localparam logic [15:0]   c_HOLD_LAST = 16'((HOLD > 0) ? (HOLD - 1) : 0);

  logic [2:0]    r_state;
  logic [aw-1:0] r_addr;
  logic [15:0]   r_cnt;
  logic [7:0]    r_err;
  logic [aw-1:0] r_first_addr;
  logic [dw-1:0] r_first_data;

  logic [dw-1:0] w_expected;
  logic          w_mismatch;
  logic          w_last;
  logic          w_stop;

  // Cast zero-extends (or truncates) the address to the data width.
  assign w_expected = SEED ^ dw'(r_addr);
  assign w_mismatch = (q != w_expected);
  assign w_last     = (r_addr == c_END);

`ifdef STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk_a) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_ISSUE;
            r_addr       <= c_START;
            r_err        <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end

        S_WAIT: begin
          if (r_cnt == c_LAT_LAST) begin
            r_state <= S_COMPARE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_COMPARE: begin
          if (w_mismatch) begin
            // A zero count means this is the first mismatch of the scan.
            if (r_err == 8'd0) begin
              r_first_addr <= r_addr;
              r_first_data <= q;
            end
            if (r_err != 8'hFF) begin
              r_err <= r_err + 8'd1;
            end
          end
          if (w_stop) begin
            r_state <= S_DONE;
          end else if (HOLD > 0) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_ISSUE;
          end
        end

        S_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_ISSUE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr           = r_addr;
  assign we             = 1'b0;
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err == 8'd0);
  assign err_count      = r_err;
  assign first_err_addr = r_first_addr;
  assign first_err_data = r_first_data;

endmodule
`default_nettype wire
